// File: rtl/prog_mem_loader.sv
// Parametrised instruction memory with HALT-fill clear sequencer, streaming load port and fetch port.
// Define COMB_FETCH_EN for the legacy zero-latency combinational fetch; default is a registered fetch.
module prog_mem_loader #(
  parameter int unsigned           DATA_W    = 8,
  parameter int unsigned           ADDR_W    = 8,
  parameter int unsigned           DEPTH     = 32,
  parameter logic [DATA_W-1:0]     HALT_WORD = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy
);

  localparam int unsigned         IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0]     PtrLast   = IdxW'(DEPTH - 1);
  localparam logic [ADDR_W:0]     DepthExt  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic              load_pend_q;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              in_range;
  logic [DATA_W-1:0] rd_data;

  assign accept    = (state_q == StLoad) && ld_valid && ld_ready_q;
  assign mem_we    = (state_q == StClear) || accept;
  assign mem_wdata = (state_q == StClear) ? HALT_WORD : ld_data;

  // Out-of-range addresses never alias, so a runaway PC always reads HALT.
  assign in_range  = {1'b0, fetch_addr} < DepthExt;
  assign rd_data   = in_range ? mem[fetch_addr[IdxW-1:0]] : HALT_WORD;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      ptr_q       <= '0;
      load_pend_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      ld_done_q <= 1'b0;
      unique case (state_q)
        StClear: begin
          if (ptr_q == PtrLast) begin
            ptr_q       <= '0;
            load_pend_q <= 1'b0;
            if (load_pend_q) begin
              state_q    <= StLoad;
              ld_ready_q <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b0;
            end
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        StLoad: begin
          if (accept) begin
            if (ld_last || (ptr_q == PtrLast)) begin
              state_q    <= StRun;
              ptr_q      <= '0;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (ld_start) begin
            state_q     <= StClear;
            ptr_q       <= '0;
            load_pend_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= StClear;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign ld_ready = ld_ready_q;
  assign ld_done  = ld_done_q;
  assign busy     = busy_q;

`ifdef COMB_FETCH_EN
  assign fetch_data  = rd_data;
  assign fetch_valid = fetch_req && !busy_q;
`else
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;

  // A fetch in the same cycle as ld_start still sees the pre-clear contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_data_q  <= HALT_WORD;
      fetch_valid_q <= 1'b0;
    end else if ((state_q == StRun) && fetch_req) begin
      fetch_data_q  <= rd_data;
      fetch_valid_q <= 1'b1;
    end else begin
      fetch_valid_q <= 1'b0;
    end
  end

  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: table-driven fetch vectors plus directed load/clear sequences.
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       fetch_valid;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       ld_done;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] words [64];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  prog_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One fetch; checks data/valid at the point the result is defined for this build.
  task automatic do_fetch(input logic [7:0] addr, input logic [7:0] exp, input string name);
    fetch_req  = 1'b1;
    fetch_addr = addr;
`ifdef COMB_FETCH_EN
    #1;
    chk({name, " valid"}, 32'(fetch_valid), 32'd1);
    chk({name, " data"}, 32'(fetch_data), 32'(exp));
    tick();
`else
    tick();
    chk({name, " valid"}, 32'(fetch_valid), 32'd1);
    chk({name, " data"}, 32'(fetch_data), 32'(exp));
`endif
    fetch_req = 1'b0;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      do_fetch(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d addr%0d", i, vecs[i].addr));
    end
  endtask

  // Count cycles until busy falls, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic start_load();
    int w;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("busy after ld_start", 32'(busy), 32'd1);
    w = 0;
    while (!ld_ready && w < 100) begin
      tick();
      w++;
    end
    chk("ld_ready after clear", 32'(ld_ready), 32'd1);
  endtask

  // Offer n words from words[], one offer per valid cycle; gap drops ld_valid every other cycle.
  task automatic stream(input int n, input int last_idx, input bit gap, input bit tail,
                        output int acc, output int done_cnt);
    int  offers;
    bit  acc_now;
    acc      = 0;
    done_cnt = 0;
    offers   = 0;
    for (int c = 0; offers < n && c < 400; c++) begin
      if (gap && (c % 2 == 1)) begin
        ld_valid = 1'b0;
        ld_last  = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_data  = words[offers];
        ld_last  = (offers == last_idx);
      end
      acc_now = ld_valid && ld_ready;
      if (ld_valid) offers++;
      tick();
      if (acc_now) acc++;
      if (ld_done) done_cnt++;
    end
    if (tail) begin
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick();
        if (ld_done) done_cnt++;
      end
    end
  endtask

  initial begin
    int cnt, acc, dn;
    vecs[0]  = '{8'd0,   8'hB3};
    vecs[1]  = '{8'd3,   8'h91};
    vecs[2]  = '{8'd4,   8'hFF};
    vecs[3]  = '{8'd5,   8'hFF};
    vecs[4]  = '{8'd1,   8'hFF};
    vecs[5]  = '{8'd0,   8'h00};
    vecs[6]  = '{8'd5,   8'h05};
    vecs[7]  = '{8'd31,  8'h1F};
    vecs[8]  = '{8'd32,  8'hFF};
    vecs[9]  = '{8'd40,  8'hFF};
    vecs[10] = '{8'd255, 8'hFF};

    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #12;
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst ld_ready", 32'(ld_ready), 32'd0);
    chk("rst ld_done", 32'(ld_done), 32'd0);
    chk("rst fetch_valid", 32'(fetch_valid), 32'd0);
`ifndef COMB_FETCH_EN
    chk("rst fetch_data", 32'(fetch_data), 32'hFF);
`endif
    tick();
    rst_n = 1'b1;
    count_busy(cnt);
    chk("initial clear cycles", 32'(cnt), 32'd32);
    chk("no load after reset clear", 32'(ld_ready), 32'd0);

    // Back-to-back fetch of the whole array after the HALT fill
    for (int i = 0; i < 32; i++) do_fetch(8'(i), 8'hFF, $sformatf("fill addr%0d", i));
    tick();
    chk("idle fetch_valid", 32'(fetch_valid), 32'd0);
`ifndef COMB_FETCH_EN
    chk("idle fetch_data hold", 32'(fetch_data), 32'hFF);
`endif

    // Short load with ld_last on the 5th word
    words[0] = 8'hB3; words[1] = 8'hFF; words[2] = 8'hFF; words[3] = 8'h91; words[4] = 8'hFF;
    start_load();
    stream(5, 4, 1'b0, 1'b1, acc, dn);
    chk("load5 accepted", 32'(acc), 32'd5);
    chk("load5 done pulses", 32'(dn), 32'd1);
    chk("load5 busy", 32'(busy), 32'd0);
    apply_vecs(0, 4);

    // Fetch in the same RUN cycle as ld_start sees old contents
    fetch_req = 1'b1; fetch_addr = 8'd3; ld_start = 1'b1;
    tick();
    fetch_req = 1'b0; ld_start = 1'b0;
`ifndef COMB_FETCH_EN
    chk("contention valid", 32'(fetch_valid), 32'd1);
    chk("contention data", 32'(fetch_data), 32'h91);
`endif
    chk("contention busy", 32'(busy), 32'd1);
    fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    chk("fetch in clear invalid", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0;
    cnt = 0;
    while (!ld_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("enter load after contention", 32'(ld_ready), 32'd1);

    // Overflow: 40 words offered, no ld_last
    for (int i = 0; i < 40; i++) words[i] = 8'(i);
    stream(40, -1, 1'b0, 1'b1, acc, dn);
    chk("overflow accepted", 32'(acc), 32'd32);
    chk("overflow done pulses", 32'(dn), 32'd1);
    chk("overflow ld_ready low", 32'(ld_ready), 32'd0);
    apply_vecs(5, 10);

    // Gapped load: ld_valid every other cycle
    for (int i = 0; i < 6; i++) words[i] = 8'hA0 + 8'(i);
    start_load();
    stream(6, 5, 1'b1, 1'b1, acc, dn);
    chk("gap accepted", 32'(acc), 32'd6);
    chk("gap done pulses", 32'(dn), 32'd1);
    for (int i = 0; i < 6; i++) do_fetch(8'(i), 8'hA0 + 8'(i), $sformatf("gap addr%0d", i));
    do_fetch(8'd6, 8'hFF, "gap addr6 cleared");

    // Reset after 3 of 5 load words
    for (int i = 0; i < 5; i++) words[i] = 8'h50 + 8'(i);
    start_load();
    stream(3, -1, 1'b0, 1'b0, acc, dn);
    rst_n = 1'b0;
    #1;
    chk("midload rst fetch_valid", 32'(fetch_valid), 32'd0);
    chk("midload rst ld_ready", 32'(ld_ready), 32'd0);
    chk("midload rst busy", 32'(busy), 32'd1);
    ld_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    // ld_start and fetch_req during CLEAR are ignored
    ld_start = 1'b1; fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    ld_start = 1'b0;
    chk("fetch during reset clear", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0;
    count_busy(cnt);
    chk("midload clear cycles", 32'(cnt + 1), 32'd32);
    chk("ld_start in clear ignored", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 3; i++) do_fetch(8'(i), 8'hFF, $sformatf("post-rst addr%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
